// File: rtl/pong_pkg.sv
// Shared Pong definitions: sequencer states, colour-mux screen codes and speaker codes.
// The ColorController select decoding uses the same codes.
package pong_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        CREDITS   = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        PAUSED    = 3'd4,
        LIFE_LOST = 3'd5,
        GAME_OVER = 3'd6
    } state_e;

    localparam logic [1:0] SCREEN_MENU    = 2'd0;
    localparam logic [1:0] SCREEN_GAME    = 2'd1;
    localparam logic [1:0] SCREEN_CREDITS = 2'd2;
    localparam logic [1:0] SCREEN_OVER    = 2'd3;

    localparam logic [1:0] SPK_MENU   = 2'd0;
    localparam logic [1:0] SPK_GAME   = 2'd1;
    localparam logic [1:0] SPK_SILENT = 2'd2;

    // Two-digit BCD a >= b: the tens digits decide, and the ones break a tie.
    function automatic logic bcd2_ge(input logic [3:0] a_tens, input logic [3:0] a_ones,
                                     input logic [3:0] b_tens, input logic [3:0] b_ones);
        return (a_tens > b_tens) || ((a_tens == b_tens) && (a_ones >= b_ones));
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter that saturates at 99, with a >= compare against a reference value.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [3:0] ref_tens,
    input  logic [3:0] ref_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ge_ref
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clear) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc && !((tens_q == 4'd9) && (ones_q == 4'd9))) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens   = tens_q;
    assign ones   = ones_q;
    assign ge_ref = bcd2_ge(tens_q, ones_q, ref_tens, ref_ones);

endmodule

// File: rtl/game_state_sequencer.sv
// Pong top-level sequencer: menu, credits, countdown, play, pause, life-lost hold and game over.
// Owns score, high score and lives; every output is registered.
module game_state_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_DIV        = 25000000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int HOLD_TICKS      = 2,
    parameter int START_LIVES     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pulse,
    input  logic       menu_select,
    input  logic       scored_pulse,
    input  logic       missed_pulse,
    output logic [1:0] screen_sel,
    output logic       pause,
    output logic [1:0] speaker_sel,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] hi_tens,
    output logic [3:0] hi_ones,
    output logic [1:0] lives,
    output logic [3:0] countdown
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [3:0]    CD_LOAD    = 4'(COUNTDOWN_TICKS);
    localparam logic [1:0]    LIVES_LOAD = 2'(START_LIVES);
    localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_TICKS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    hold_q, hold_d;
    logic [3:0]    cd_q, cd_d;
    logic [1:0]    lives_q, lives_d;
    logic [3:0]    hi_tens_q, hi_tens_d;
    logic [3:0]    hi_ones_q, hi_ones_d;
    logic [1:0]    screen_q, screen_d;
    logic          pause_q, pause_d;
    logic [1:0]    spk_q, spk_d;

    logic          timed_state;
    logic          tick;
    logic          score_clear;
    logic          score_inc;
    logic          score_ge_hi;

    assign timed_state = (state_q == COUNTDOWN) || (state_q == LIFE_LOST);
    assign tick        = timed_state && (pre_q == PRE_LAST);

    bcd2_counter u_score (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (score_clear),
        .inc      (score_inc),
        .ref_tens (hi_tens_q),
        .ref_ones (hi_ones_q),
        .tens     (score_tens),
        .ones     (score_ones),
        .ge_ref   (score_ge_hi)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cd_d        = cd_q;
        lives_d     = lives_q;
        hi_tens_d   = hi_tens_q;
        hi_ones_d   = hi_ones_q;
        score_clear = 1'b0;
        score_inc   = 1'b0;
        case (state_q)
            MENU: begin
                if (btn_pulse) begin
                    if (!menu_select) begin
                        state_d     = COUNTDOWN;
                        score_clear = 1'b1;
                        lives_d     = LIVES_LOAD;
                        cd_d        = CD_LOAD;
                    end else begin
                        state_d = CREDITS;
                    end
                end
            end
            CREDITS: if (btn_pulse) state_d = MENU;
            COUNTDOWN: begin
                if (tick) begin
                    cd_d = cd_q - 4'd1;
                    if (cd_q <= 4'd1) state_d = PLAY;
                end
            end
            PLAY: begin
                // A miss overrides both a simultaneous hit and a pause request.
                if (missed_pulse) begin
                    if (lives_q > 2'd1) begin
                        state_d = LIFE_LOST;
                        lives_d = lives_q - 2'd1;
                    end else begin
                        state_d = GAME_OVER;
                        lives_d = 2'd0;
                        if (score_ge_hi) begin
                            hi_tens_d = score_tens;
                            hi_ones_d = score_ones;
                        end
                    end
                end else begin
                    score_inc = scored_pulse;
                    if (btn_pulse) state_d = PAUSED;
                end
            end
            PAUSED: if (btn_pulse) state_d = PLAY;
            LIFE_LOST: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) state_d = PLAY;
                    else                     hold_d  = hold_q + 8'd1;
                end
            end
            GAME_OVER: if (btn_pulse) state_d = MENU;
            default: state_d = MENU;
        endcase

        // Prescaler and hold count restart from zero whenever a state is entered.
        if (state_d != state_q) begin
            pre_d  = '0;
            hold_d = 8'd0;
        end else if (!timed_state || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        screen_d = SCREEN_GAME;
        spk_d    = SPK_SILENT;
        pause_d  = 1'b1;
        case (state_d)
            MENU: begin
                screen_d = SCREEN_MENU;
                spk_d    = SPK_MENU;
            end
            CREDITS: begin
                screen_d = SCREEN_CREDITS;
                spk_d    = SPK_MENU;
            end
            PLAY: begin
                pause_d = 1'b0;
                spk_d   = SPK_GAME;
            end
            GAME_OVER: screen_d = SCREEN_OVER;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MENU;
            pre_q     <= '0;
            hold_q    <= 8'd0;
            cd_q      <= 4'd0;
            lives_q   <= LIVES_LOAD;
            hi_tens_q <= 4'd0;
            hi_ones_q <= 4'd0;
            screen_q  <= SCREEN_MENU;
            pause_q   <= 1'b1;
            spk_q     <= SPK_MENU;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            cd_q      <= cd_d;
            lives_q   <= lives_d;
            hi_tens_q <= hi_tens_d;
            hi_ones_q <= hi_ones_d;
            screen_q  <= screen_d;
            pause_q   <= pause_d;
            spk_q     <= spk_d;
        end
    end

    assign screen_sel  = screen_q;
    assign pause       = pause_q;
    assign speaker_sel = spk_q;
    assign hi_tens     = hi_tens_q;
    assign hi_ones     = hi_ones_q;
    assign lives       = lives_q;
    assign countdown   = cd_q;

endmodule
